// File: rtl/tape_player.sv
// Cassette playback source: streams an image from memory as MSB-first Manchester symbols
// on tapeout, with a one-byte prefetch buffer so consecutive bytes play back to back.
module tape_player #(
    parameter int HALF_BIT = 4224,
    parameter int AW       = 20
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] img_size,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ack,
    input  logic [7:0]    rd_data,
    output logic          tapeout,
    output logic          busy,
    output logic          done
);

    localparam int HW = (HALF_BIT > 2) ? $clog2(HALF_BIT) : 1;
    localparam logic [HW-1:0] HC_LAST = HW'(HALF_BIT - 1);

    typedef enum logic [1:0] {IDLE, FIRST, SEND, STALL} state_t;

    state_t        state;
    logic [AW-1:0] size_r;
    logic [AW-1:0] fa;
    logic [AW-1:0] fa_inc;
    logic [7:0]    sr;
    logic [7:0]    pb;
    logic [2:0]    bc;
    logic          h;
    logic          pv;
    logic [HW-1:0] hc;
    logic          take;
    logic          more;
    logic          more_after;
    logic          eob;

    assign fa_inc     = fa + AW'(1);
    // An acknowledge only counts against an outstanding request.
    assign take       = rd_ack && rd_req;
    assign more       = fa < size_r;
    assign more_after = fa_inc < size_r;
    assign eob        = (hc == '0) && h && (bc == 3'd7);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            size_r  <= '0;
            fa      <= '0;
            sr      <= '0;
            pb      <= '0;
            bc      <= '0;
            h       <= 1'b0;
            pv      <= 1'b0;
            hc      <= '0;
            rd_req  <= 1'b0;
            rd_addr <= '0;
            tapeout <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop && state != IDLE) begin
                state   <= IDLE;
                busy    <= 1'b0;
                rd_req  <= 1'b0;
                tapeout <= 1'b0;
                pv      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            size_r  <= img_size;
                            fa      <= '0;
                            pv      <= 1'b0;
                            rd_addr <= '0;
                            if (img_size == '0) begin
                                done <= 1'b1;
                            end else begin
                                state  <= FIRST;
                                busy   <= 1'b1;
                                rd_req <= 1'b1;
                            end
                        end
                    end
                    FIRST, STALL: begin
                        if (take) begin
                            sr      <= rd_data;
                            bc      <= '0;
                            h       <= 1'b0;
                            hc      <= HC_LAST;
                            fa      <= fa_inc;
                            tapeout <= ~rd_data[7];
                            rd_req  <= more_after;
                            rd_addr <= fa_inc;
                            state   <= SEND;
                        end
                    end
                    SEND: begin
                        // Prefetch capture; at end of byte the ack feeds the shifter directly.
                        if (!eob && take) begin
                            pb     <= rd_data;
                            pv     <= 1'b1;
                            fa     <= fa_inc;
                            rd_req <= 1'b0;
                        end
                        if (hc != '0) begin
                            hc <= hc - HW'(1);
                        end else if (!h) begin
                            h       <= 1'b1;
                            hc      <= HC_LAST;
                            tapeout <= sr[7];
                        end else if (bc != 3'd7) begin
                            sr      <= {sr[6:0], 1'b0};
                            bc      <= bc + 3'd1;
                            h       <= 1'b0;
                            hc      <= HC_LAST;
                            tapeout <= ~sr[6];
                        end else if (pv) begin
                            sr      <= pb;
                            pv      <= 1'b0;
                            bc      <= '0;
                            h       <= 1'b0;
                            hc      <= HC_LAST;
                            tapeout <= ~pb[7];
                            rd_req  <= more;
                            rd_addr <= fa;
                        end else if (take) begin
                            sr      <= rd_data;
                            fa      <= fa_inc;
                            bc      <= '0;
                            h       <= 1'b0;
                            hc      <= HC_LAST;
                            tapeout <= ~rd_data[7];
                            rd_req  <= more_after;
                            rd_addr <= fa_inc;
                        end else if (!more) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            tapeout <= 1'b0;
                            rd_req  <= 1'b0;
                        end else begin
                            state <= STALL;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player: table of whole-image playbacks plus hand-written
// sequences for stall, abort, zero-length image and asynchronous reset.
module tb_tape_player;
    localparam int HB = 4;
    localparam int AW = 8;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [AW-1:0] img_size;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    wire           rd_ack;
    wire  [7:0]    rd_data;
    logic          tapeout;
    logic          busy;
    logic          done;

    tape_player #(.HALF_BIT(HB), .AW(AW)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .img_size(img_size),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .tapeout (tapeout),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Memory responder: acks each request lat cycles after it is seen, on the falling edge.
    logic          auto_ack = 1'b0;
    logic [7:0]    auto_data = 8'h00;
    logic          man_ack;
    logic [7:0]    man_data;
    logic          mem_en;
    int            lat;
    int            age = 0;
    logic [7:0]    mem [0:255];
    int            ack_cyc[$];
    logic [AW-1:0] req_addr[$];

    assign rd_ack  = auto_ack | man_ack;
    assign rd_data = man_ack ? man_data : auto_data;

    always @(negedge clk_sys) begin
        if (mem_en && rd_req && !reset) begin
            if (age + 1 >= lat) begin
                auto_ack  <= 1'b1;
                auto_data <= mem[rd_addr];
                age       <= 0;
                ack_cyc.push_back(cyc);
                req_addr.push_back(rd_addr);
            end else begin
                auto_ack <= 1'b0;
                age      <= age + 1;
            end
        end else begin
            auto_ack <= 1'b0;
            age      <= 0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_start(input int size);
        img_size = AW'(size);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_acks(input int want, input int budget, output bit ok);
        int b = 0;
        while (ack_cyc.size() < want && b < budget) begin
            step();
            b++;
        end
        ok = (ack_cyc.size() >= want);
    endtask

    typedef struct {
        int          size;
        logic [23:0] bytes;
        int          lat;
        logic [47:0] halves;
        int          inj;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v, input int idx);
        int a0;
        int errs;
        int total;
        bit ok;
        lat    = v.lat;
        mem[0] = v.bytes[23:16];
        mem[1] = v.bytes[15:8];
        mem[2] = v.bytes[7:0];
        ack_cyc.delete();
        req_addr.delete();
        pulse_start(v.size);
        check($sformatf("v%0d_busy_t1", idx), busy, 1);
        check($sformatf("v%0d_req_t1", idx), rd_req, 1);
        wait_acks(1, 60, ok);
        if (!ok) begin
            check($sformatf("v%0d_first_ack_timeout", idx), 0, 1);
            return;
        end
        a0 = ack_cyc[0];
        while (cyc < a0 + 1) step();
        errs  = 0;
        total = v.size * 16 * HB;
        for (int k = 0; k < total; k++) begin
            if (tapeout !== v.halves[47 - k / HB] || busy !== 1'b1 || done !== 1'b0) errs++;
            start = (k == v.inj);
            if (k == v.inj) img_size = AW'(1);
            step();
        end
        start = 1'b0;
        check($sformatf("v%0d_stream_errs", idx), errs, 0);
        check($sformatf("v%0d_done", idx), done, 1);
        check($sformatf("v%0d_busy_end", idx), busy, 0);
        check($sformatf("v%0d_tape_end", idx), tapeout, 0);
        check($sformatf("v%0d_req_count", idx), ack_cyc.size(), v.size);
        for (int i = 0; i < v.size && i < ack_cyc.size(); i++) begin
            check($sformatf("v%0d_addr%0d", idx, i), req_addr[i], i);
            if (i > 0) check($sformatf("v%0d_prefetch%0d", idx, i),
                             ack_cyc[i] <= a0 + 16 * HB * i, 1);
        end
        step();
        check($sformatf("v%0d_done_drop", idx), done, 0);
    endtask

    initial begin
        int a0;
        int errs;
        bit ok;
        reset = 1'b1; start = 1'b0; stop = 1'b0; img_size = '0;
        man_ack = 1'b0; man_data = 8'h00; mem_en = 1'b1; lat = 2;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vecs[0] = '{1, 24'hA50000, 2, {16'h6699, 32'h0}, -1};
        vecs[1] = '{3, 24'h00FF3C, 5, {16'hAAAA, 16'h5555, 16'hA55A}, -1};
        vecs[2] = '{2, 24'h3CA500, 1, {16'hA55A, 16'h6699, 16'h0}, -1};
        vecs[3] = '{3, 24'h00FF3C, 5, {16'hAAAA, 16'h5555, 16'hA55A}, 20};

        step(); step();
        check("rst_req", rd_req, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_tape", tapeout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Zero-length image
        ack_cyc.delete();
        pulse_start(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rd_req !== 1'b0 || busy !== 1'b0) errs++;
            if (i == 0) check("zero_done_drop", done, 0);
        end
        check("zero_idle_errs", errs, 0);

        // Underrun: second byte arrives after the first has finished
        mem[0] = 8'hA5; mem[1] = 8'hC3; lat = 80;
        ack_cyc.delete(); req_addr.delete();
        pulse_start(2);
        wait_acks(1, 200, ok);
        if (!ok) check("stall_first_timeout", 0, 1);
        else begin
            a0 = ack_cyc[0];
            while (cyc < a0 + 65) step();
            errs = 0;
            for (int b = 0; b < 200 && ack_cyc.size() < 2; b++) begin
                if (tapeout !== 1'b1 || busy !== 1'b1) errs++;
                step();
            end
            if (ack_cyc.size() < 2) check("stall_second_timeout", 0, 1);
            else begin
                check("stall_hold_errs", errs, 0);
                check("stall_entered", ack_cyc[1] > a0 + 64, 1);
                check("stall_resume_h0", tapeout, 0);
                for (int i = 0; i < HB; i++) step();
                check("stall_resume_h1", tapeout, 1);
                for (int i = 0; i < 64 - HB; i++) step();
                check("stall_done", done, 1);
                check("stall_busy_end", busy, 0);
            end
        end
        lat = 2;

        // Plain abort mid-byte, then replay from address 0
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h3C;
        ack_cyc.delete(); req_addr.delete();
        pulse_start(3);
        wait_acks(1, 60, ok);
        a0 = ok ? ack_cyc[0] : cyc;
        while (cyc < a0 + 1 + HB + 1) step();
        check("stop_pre_tape", tapeout, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_tape", tapeout, 0);
        check("stop_req", rd_req, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("stop_quiet_errs", errs, 0);
        ack_cyc.delete(); req_addr.delete();
        pulse_start(3);
        wait_acks(1, 60, ok);
        check("replay_addr0", ok ? req_addr[0] : 8'hFF, 0);
        stop = 1'b1; step(); stop = 1'b0;

        // Abort coinciding with a prefetch acknowledge
        mem_en = 1'b0;
        pulse_start(3);
        check("coin_first_req", rd_req, 1);
        man_data = 8'hFF; man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("coin_pref_req", rd_req, 1);
        check("coin_pref_addr", rd_addr, 1);
        step(); step();
        man_data = 8'h55; man_ack = 1'b1; stop = 1'b1;
        step();
        man_ack = 1'b0; stop = 1'b0;
        check("coin_busy", busy, 0);
        check("coin_req", rd_req, 0);
        check("coin_tape", tapeout, 0);
        check("coin_done", done, 0);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        step();
        check("stray_ack_busy", busy, 0);
        check("stray_ack_tape", tapeout, 0);
        mem_en = 1'b1;

        // Asynchronous reset during SEND
        ack_cyc.delete(); req_addr.delete();
        pulse_start(3);
        wait_acks(1, 60, ok);
        a0 = ok ? ack_cyc[0] : cyc;
        while (cyc < a0 + 1 + HB) step();
        check("pre_reset_tape", tapeout, 1);
        check("pre_reset_addr", rd_addr, 1);
        #2 reset = 1'b1;
        #1;
        check("async_tape", tapeout, 0);
        check("async_busy", busy, 0);
        check("async_addr", rd_addr, 0);
        check("async_req", rd_req, 0);
        step();
        reset = 1'b0;
        ack_cyc.delete(); req_addr.delete();
        pulse_start(1);
        wait_acks(1, 60, ok);
        check("post_reset_addr0", ok ? req_addr[0] : 8'hFF, 0);
        check("post_reset_busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
